// File: rtl/elevator_floor_ctrl.sv
// elevator_floor_ctrl: SCAN car scheduler with latched floor calls, travel/door timers
// and a registered BCD floor code for the seven-segment decoder.
module elevator_floor_ctrl #(
    parameter int NUM_FLOORS  = 10,
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [3:0]            floor_bcd,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);
    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              floor_q, floor_d, nf;
    logic [MW-1:0]           move_q, move_d;
    logic [DW-1:0]           door_q, door_d;
    logic                    dir_q, dir_d, up;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d, req_eff;

    // True when any request lies strictly beyond floor f in direction up (1) / down (0).
    function automatic logic dir_req(input logic [NUM_FLOORS-1:0] r, input logic [3:0] f,
                                     input logic u);
        dir_req = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (r[i] && (u ? i > int'(f) : i < int'(f))) dir_req = 1'b1;
    endfunction

    always_comb begin
        req_eff   = pending_q | call_req;
        state_d   = state_q;
        floor_d   = floor_q;
        move_d    = move_q;
        door_d    = door_q;
        dir_d     = dir_q;
        pending_d = req_eff;
        up        = state_q == MOVE_UP;
        nf        = up ? (floor_q == 4'(NUM_FLOORS - 1) ? floor_q : floor_q + 4'd1)
                       : (floor_q == 4'd0 ? floor_q : floor_q - 4'd1);
        case (state_q)
            IDLE: begin
                move_d = '0;
                if (req_eff[floor_q]) begin
                    state_d            = DOOR_OPEN;
                    pending_d[floor_q] = 1'b0;
                    door_d             = '0;
                end else if (dir_req(req_eff, floor_q, 1'b1) &&
                             (dir_q || !dir_req(req_eff, floor_q, 1'b0))) begin
                    state_d = MOVE_UP;
                end else if (dir_req(req_eff, floor_q, 1'b0)) begin
                    state_d = MOVE_DOWN;
                end
            end
            DOOR_OPEN: begin
                // Calls for the open floor are absorbed rather than latched.
                pending_d[floor_q] = 1'b0;
                door_d             = door_q + DW'(1);
                if (door_q == DW'(DOOR_CYCLES - 1)) begin
                    door_d = '0;
                    move_d = '0;
                    if (dir_req(pending_d, floor_q, dir_q))
                        state_d = dir_q ? MOVE_UP : MOVE_DOWN;
                    else if (dir_req(pending_d, floor_q, !dir_q))
                        state_d = dir_q ? MOVE_DOWN : MOVE_UP;
                    else
                        state_d = IDLE;
                end
            end
            default: begin
                move_d = move_q + MW'(1);
                if (move_q == MW'(MOVE_CYCLES - 1)) begin
                    move_d  = '0;
                    floor_d = nf;
                    dir_d   = up;
                    if (req_eff[nf]) begin
                        state_d       = DOOR_OPEN;
                        pending_d[nf] = 1'b0;
                        door_d        = '0;
                    end else if (!dir_req(req_eff, nf, up)) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            move_q    <= '0;
            door_q    <= '0;
            dir_q     <= 1'b1;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            move_q    <= move_d;
            door_q    <= door_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
        end
    end

    assign floor_bcd   = floor_q;
    assign moving_up   = state_q == MOVE_UP;
    assign moving_down = state_q == MOVE_DOWN;
    assign door_open   = state_q == DOOR_OPEN;
    assign pending     = pending_q;
    assign busy        = (state_q != IDLE) || (|pending_q);
endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// tb_elevator_floor_ctrl: directed stimulus with a stop-order scoreboard checked on
// every door opening, plus cycle-exact checks of the floor indicator path.
module tb_elevator_floor_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] call_req = '0;
    logic [3:0] floor_bcd;
    logic       moving_up, moving_down, door_open, busy;
    logic [9:0] pending;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    logic door_prev = 1'b0;

    elevator_floor_ctrl #(.NUM_FLOORS(10), .MOVE_CYCLES(8), .DOOR_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .call_req(call_req), .floor_bcd(floor_bcd),
        .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open),
        .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [9:0] m);
        call_req = m;
        tick();
        call_req = '0;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        call_req = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_floor(input int f);
        int n = 0;
        while (floor_bcd != 4'(f) && n < 300) begin
            tick();
            n++;
        end
        check("wait_floor", 32'(floor_bcd), 32'(f));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check("wait_idle_busy", 32'(busy), 0);
    endtask

    // Monitor: every door opening is a stop; it must match the next predicted floor.
    initial forever begin
        @(negedge clk);
        if (rst_n && door_open && !door_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stop_unexpected: got floor %0d, expected no stop", floor_bcd);
            end else begin
                check("stop_floor", 32'(floor_bcd), 32'(exp_q.pop_front()));
                check("stop_pending_clr", 32'(pending[floor_bcd]), 0);
            end
        end
        door_prev = door_open;
    end

    initial begin
        // Reset state
        apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_floor", 32'(floor_bcd), 0);
        check("rst_up", 32'(moving_up), 0);
        check("rst_down", 32'(moving_down), 0);
        check("rst_door", 32'(door_open), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        rst_n = 1'b1;
        tick();
        // Single call to floor 3
        exp_q.push_back(3);
        pulse(10'h008);
        check("single_up_E0", 32'(moving_up), 1);
        check("single_busy_E0", 32'(busy), 1);
        check("single_pend_E0", 32'(pending), 32'h008);
        repeat (8) tick();
        check("single_floor_E8", 32'(floor_bcd), 1);
        repeat (8) tick();
        check("single_floor_E16", 32'(floor_bcd), 2);
        check("single_up_E16", 32'(moving_up), 1);
        repeat (8) tick();
        check("single_floor_E24", 32'(floor_bcd), 3);
        check("single_door_E24", 32'(door_open), 1);
        check("single_up_E24", 32'(moving_up), 0);
        check("single_pend_E24", 32'(pending), 0);
        repeat (3) tick();
        check("single_door_E27", 32'(door_open), 1);
        tick();
        check("single_door_E28", 32'(door_open), 0);
        check("single_busy_E28", 32'(busy), 0);
        check("single_move_E28", 32'({moving_up, moving_down}), 0);
        check("single_floor_E28", 32'(floor_bcd), 3);
        // SCAN order: 5 called, then 1 and 4 while passing floor 2
        apply_reset();
        pulse(10'h020);
        wait_floor(2);
        exp_q.push_back(4);
        exp_q.push_back(5);
        exp_q.push_back(1);
        pulse(10'h012);
        check("scan_pend", 32'(pending), 32'h032);
        wait_floor(5);
        check("scan_door5", 32'(door_open), 1);
        repeat (4) tick();
        check("scan_reverse", 32'(moving_down), 1);
        wait_idle();
        check("scan_final_floor", 32'(floor_bcd), 1);
        // Current-floor call with a re-pulse mid-door
        apply_reset();
        exp_q.push_back(2);
        pulse(10'h004);
        wait_idle();
        check("cur_floor_start", 32'(floor_bcd), 2);
        exp_q.push_back(2);
        pulse(10'h004);
        check("cur_door_E0", 32'(door_open), 1);
        check("cur_move_E0", 32'({moving_up, moving_down}), 0);
        tick();
        call_req = 10'h004;
        tick();
        call_req = '0;
        check("cur_absorb_pend", 32'(pending[2]), 0);
        check("cur_door_E2", 32'(door_open), 1);
        tick();
        check("cur_door_E3", 32'(door_open), 1);
        tick();
        check("cur_door_E4", 32'(door_open), 0);
        check("cur_busy_E4", 32'(busy), 0);
        check("cur_floor_E4", 32'(floor_bcd), 2);
        // Asynchronous reset mid-move
        apply_reset();
        pulse(10'h060);
        wait_floor(3);
        repeat (3) tick();
        check("ar_pend", 32'(pending), 32'h060);
        check("ar_up", 32'(moving_up), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_floor", 32'(floor_bcd), 0);
        check("ar_outs", 32'({moving_up, moving_down, door_open, busy}), 0);
        check("ar_pend_clr", 32'(pending), 0);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        check("ar_idle_busy", 32'(busy), 0);
        check("ar_idle_floor", 32'(floor_bcd), 0);
        // Arrival race at floor 2
        apply_reset();
        exp_q.push_back(1);
        pulse(10'h002);
        wait_idle();
        pulse(10'h020);
        repeat (7) tick();
        check("race_floor_E7", 32'(floor_bcd), 1);
        exp_q.push_back(2);
        exp_q.push_back(5);
        call_req = 10'h004;
        tick();
        call_req = '0;
        check("race_floor_E8", 32'(floor_bcd), 2);
        check("race_door_E8", 32'(door_open), 1);
        check("race_pend_E8", 32'(pending), 32'h020);
        wait_idle();
        check("race_final_floor", 32'(floor_bcd), 5);
        repeat (2) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
